// File: rtl/button_step_counter.sv
// button_step_counter: two raw push-buttons step a 4-bit LED count up/down.
// Each button: 2-flop synchroniser -> debounce timer -> rising-edge pulse.
// Q steps on the edge after a pulse; simultaneous up+down pulses cancel.
// Optional auto-repeat while held: define BUTTON_AUTO_REPEAT_EN.
module button_step_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
`ifdef BUTTON_AUTO_REPEAT_EN
  parameter int unsigned HOLD_CYCLES     = 62500000,
  parameter int unsigned REPEAT_CYCLES   = 12500000,
`endif
  parameter int unsigned CNT_W           = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] Q,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       wrap
);

`ifdef BUTTON_AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, HOLD_WAIT, REPEAT} btn_state_e;
  // HOLD_WAIT is entered one cycle before the initial pulse, so waiting for
  // a count of HOLD_CYCLES (not -1) spaces the first repeat exactly
  // HOLD_CYCLES after the initial pulse.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`else
  typedef enum logic {IDLE, PRESSED} btn_state_e;
`endif

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync2_q;
  btn_state_e       state_q [2];
  btn_state_e       state_d [2];
  logic [CNT_W-1:0] db_tmr_q [2];
  logic [CNT_W-1:0] db_tmr_d [2];
  logic [1:0]       db_flip;
  logic [1:0]       stable;
  logic [1:0]       stable_prev_q;
  logic [1:0]       pulse_q, pulse_d;
  logic [3:0]       q_q, q_d;
  logic             wrap_q, wrap_d;
`ifdef BUTTON_AUTO_REPEAT_EN
  logic [CNT_W-1:0] rp_tmr_q [2];
  logic [CNT_W-1:0] rp_tmr_d [2];
  logic [1:0]       rpt_fire;
`endif

  assign btn_raw = {btn_down, btn_up};

  // Two-flop synchroniser: the only path from the raw buttons into logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounced (stable) level is encoded by the per-button state.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      stable[i] = (state_q[i] != IDLE);
    end
  end

  // Debounce timers and per-button state transitions.
  always_comb begin
    db_flip = '0;
`ifdef BUTTON_AUTO_REPEAT_EN
    rpt_fire = '0;
`endif
    for (int unsigned i = 0; i < 2; i++) begin
      state_d[i]  = state_q[i];
      db_tmr_d[i] = '0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rp_tmr_d[i] = rp_tmr_q[i];
`endif
      if (sync2_q[i] != stable[i]) begin
        if (db_tmr_q[i] == DB_LAST) begin
          db_flip[i] = 1'b1;
        end else begin
          db_tmr_d[i] = db_tmr_q[i] + CNT_W'(1);
        end
      end
`ifdef BUTTON_AUTO_REPEAT_EN
      case (state_q[i])
        IDLE: begin
          if (db_flip[i]) begin
            state_d[i]  = HOLD_WAIT;
            rp_tmr_d[i] = '0;
          end
        end
        HOLD_WAIT: begin
          if (db_flip[i]) begin
            state_d[i]  = IDLE;
            rp_tmr_d[i] = '0;
          end else if (rp_tmr_q[i] == HOLD_LAST) begin
            state_d[i]  = REPEAT;
            rp_tmr_d[i] = '0;
            rpt_fire[i] = 1'b1;
          end else begin
            rp_tmr_d[i] = rp_tmr_q[i] + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (db_flip[i]) begin
            state_d[i]  = IDLE;
            rp_tmr_d[i] = '0;
          end else if (rp_tmr_q[i] == REP_LAST) begin
            rp_tmr_d[i] = '0;
            rpt_fire[i] = 1'b1;
          end else begin
            rp_tmr_d[i] = rp_tmr_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i]  = IDLE;
          rp_tmr_d[i] = '0;
        end
      endcase
`else
      case (state_q[i])
        IDLE:    if (db_flip[i]) state_d[i] = PRESSED;
        PRESSED: if (db_flip[i]) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
`endif
    end
  end

  // Per-button state, debounce timer and (optionally) repeat timer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i]  <= IDLE;
        db_tmr_q[i] <= '0;
`ifdef BUTTON_AUTO_REPEAT_EN
        rp_tmr_q[i] <= '0;
`endif
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i]  <= state_d[i];
        db_tmr_q[i] <= db_tmr_d[i];
`ifdef BUTTON_AUTO_REPEAT_EN
        rp_tmr_q[i] <= rp_tmr_d[i];
`endif
      end
    end
  end

  // Press strobe: rising edge of the stable level, plus repeat firings.
  always_comb begin
`ifdef BUTTON_AUTO_REPEAT_EN
    pulse_d = (stable & ~stable_prev_q) | rpt_fire;
`else
    pulse_d = stable & ~stable_prev_q;
`endif
  end

  // Edge-detect history and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_prev_q <= '0;
      pulse_q       <= '0;
    end else begin
      stable_prev_q <= stable;
      pulse_q       <= pulse_d;
    end
  end

  // Count step and wrap detection from the registered strobes.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    case (pulse_q)
      2'b01: begin
        q_d    = q_q + 4'd1;
        wrap_d = (q_q == 4'hF);
      end
      2'b10: begin
        q_d    = q_q - 4'd1;
        wrap_d = (q_q == 4'h0);
      end
      default: ;
    endcase
  end

  // Count and wrap strobe registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q          = q_q;
  assign up_pulse   = pulse_q[0];
  assign down_pulse = pulse_q[1];
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_button_step_counter.sv
// Directed bench for button_step_counter with DEBOUNCE_CYCLES=8,
// HOLD_CYCLES=40, REPEAT_CYCLES=10. Vector k drives inputs before edge k and
// checks outputs 1 time unit after edge k.
module tb_button_step_counter;

  logic       clk;
  logic       reset;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] Q;
  logic       up_pulse;
  logic       down_pulse;
  logic       wrap;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       up;
    logic       dn;
    logic [3:0] q;
    logic       pu;
    logic       pd;
    logic       w;
  } vec_t;

  vec_t vecs[$];

  button_step_counter #(
    .DEBOUNCE_CYCLES(8),
`ifdef BUTTON_AUTO_REPEAT_EN
    .HOLD_CYCLES(40),
    .REPEAT_CYCLES(10),
`endif
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .Q(Q),
    .up_pulse(up_pulse),
    .down_pulse(down_pulse),
    .wrap(wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic up, input logic dn, input int n,
                              input logic [3:0] q, input logic pu,
                              input logic pd, input logic w);
    for (int k = 0; k < n; k++) vecs.push_back('{up, dn, q, pu, pd, w});
  endfunction

  // Short clean press (11 cycles) then release; q0 before, q1 after.
  function automatic void add_press(input logic is_up, input logic [3:0] q0,
                                    input logic [3:0] q1, input logic w);
    add(is_up, ~is_up, 10, q0, 1'b0, 1'b0, 1'b0);
    add(is_up, ~is_up, 1, q0, is_up, ~is_up, 1'b0);
    add(1'b0, 1'b0, 1, q1, 1'b0, 1'b0, w);
    add(1'b0, 1'b0, 11, q1, 1'b0, 1'b0, 1'b0);
  endfunction

  initial begin
    int pulses;

    // ---- vector table ----
    // Clean 30-cycle press from Q=0.
    add(1, 0, 10, 4'd0, 0, 0, 0);
    add(1, 0, 1, 4'd0, 1, 0, 0);
    add(1, 0, 19, 4'd1, 0, 0, 0);
    add(0, 0, 15, 4'd1, 0, 0, 0);
    // 15 more presses: 1 -> 0, wrap on the last.
    for (int k = 0; k < 15; k++)
      add_press(1'b1, 4'(k + 1), 4'((k + 2) % 16), (k == 14));
    // Bounce on btn_down: toggles every 3 cycles for 40 cycles, then holds.
    for (int c = 0; c < 40; c++) add(0, ((c / 3) % 2) == 0, 1, 4'd0, 0, 0, 0);
    add(0, 1, 10, 4'd0, 0, 0, 0);
    add(0, 1, 1, 4'd0, 0, 1, 0);
    add(0, 1, 1, 4'd15, 0, 0, 1);
    add(0, 1, 8, 4'd15, 0, 0, 0);
    add(0, 0, 15, 4'd15, 0, 0, 0);
    // Glitch of 7 cycles: no pulse.
    add(1, 0, 7, 4'd15, 0, 0, 0);
    add(0, 0, 15, 4'd15, 0, 0, 0);
    // Exactly 8 cycles high: the shortest accepted press, wraps 15 -> 0.
    add(1, 0, 8, 4'd15, 0, 0, 0);
    add(0, 0, 2, 4'd15, 0, 0, 0);
    add(0, 0, 1, 4'd15, 1, 0, 0);
    add(0, 0, 1, 4'd0, 0, 0, 1);
    add(0, 0, 12, 4'd0, 0, 0, 0);
    // Up to 5, one plain down step and back.
    for (int k = 0; k < 5; k++) add_press(1'b1, 4'(k), 4'(k + 1), 1'b0);
    add_press(1'b0, 4'd5, 4'd4, 1'b0);
    add_press(1'b1, 4'd4, 4'd5, 1'b0);
    // Simultaneous press from Q=5: both strobes, Q holds, no wrap.
    add(1, 1, 10, 4'd5, 0, 0, 0);
    add(1, 1, 1, 4'd5, 1, 1, 0);
    add(1, 1, 5, 4'd5, 0, 0, 0);
    add(0, 0, 15, 4'd5, 0, 0, 0);

    // ---- reset with toggling buttons ----
    reset    = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_up   = i[0];
      btn_down = ~i[0];
      step();
      check($sformatf("reset_q_%0d", i), Q, 0);
      check($sformatf("reset_strobes_%0d", i), {up_pulse, down_pulse, wrap}, 0);
    end
    btn_up   = 1'b0;
    btn_down = 1'b0;
    step();
    step();
    reset = 1'b1;

    // ---- table ----
    foreach (vecs[i]) begin
      btn_up   = vecs[i].up;
      btn_down = vecs[i].dn;
      step();
      n_cmp++;
      if (Q !== vecs[i].q || up_pulse !== vecs[i].pu ||
          down_pulse !== vecs[i].pd || wrap !== vecs[i].w) begin
        n_fail++;
        $display("FAIL vec%0d: got q=%0d up=%b dn=%b wrap=%b expected q=%0d up=%b dn=%b wrap=%b",
                 i, Q, up_pulse, down_pulse, wrap,
                 vecs[i].q, vecs[i].pu, vecs[i].pd, vecs[i].w);
      end
    end

    // ---- mid-press reset ----
    btn_up = 1'b1;
    repeat (12) step();
    check("pre_reset_q", Q, 6);
    reset = 1'b0;
    #1;
    check("async_reset_q", Q, 0);
    check("async_reset_strobes", {up_pulse, down_pulse, wrap}, 0);
    repeat (3) step();
    check("held_reset_q", Q, 0);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("post_reset_up_%0d", i), up_pulse, (i == 10) ? 1 : 0);
      check($sformatf("post_reset_q_%0d", i), Q, (i == 11) ? 1 : 0);
    end
    btn_up = 1'b0;
    repeat (15) step();
    check("pre_hold_q", Q, 1);

    // ---- long hold (auto-repeat when enabled) ----
    pulses = 0;
    btn_up = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      pulses += int'(up_pulse);
    end
    btn_up = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      pulses += int'(up_pulse);
    end
`ifdef BUTTON_AUTO_REPEAT_EN
    check("hold_q_in_6_to_8", (Q >= 4'd6 && Q <= 4'd8) ? 1 : 0, 1);
    check("hold_pulses_in_5_to_7", (pulses >= 5 && pulses <= 7) ? 1 : 0, 1);
`else
    check("hold_q", Q, 2);
    check("hold_pulses", pulses, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/button_step_counter.md
Name: button_step_counter

Overview:
- Input-side counterpart to the LED binary counter: a user steps a 4-bit value up or down with two raw push-buttons.
- Each raw button is synchronised, debounced and edge-detected. Each clean press produces exactly one step of Q.
- Q drives the same 4 LEDs on the Zybo Z7-10 board. Clock is 125 MHz.

Parameters:
- DEBOUNCE_CYCLES, 1250000. Consecutive cycles the synchronised level must differ from the stable level before the stable level flips (10 ms at 125 MHz). Minimum 2.
- HOLD_CYCLES, 62500000. Auto-repeat only: cycles held before the first repeat (0.5 s).
- REPEAT_CYCLES, 12500000. Auto-repeat only: cycles between repeats (0.1 s).
- CNT_W, 27. Width of the internal timer counters. Must hold the largest of the three cycle parameters above.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- btn_up  input  1  raw, asynchronous, active-high button
- btn_down  input  1  raw, asynchronous, active-high button
- Q  output  4  current count, drives LEDs
- up_pulse  output  1  one-cycle strobe: debounced press of btn_up accepted
- down_pulse  output  1  one-cycle strobe: debounced press of btn_down accepted
- wrap  output  1  one-cycle strobe: Q wrapped (15->0 or 0->15)

Behaviour:
- Reset (reset==0, asynchronous): Q=0, up_pulse=0, down_pulse=0, wrap=0. Synchroniser flops=0, stable levels=0, all timers=0.
- Reset mid-press: the button is treated as released. After reset deasserts, a button still held must first be seen stable high for DEBOUNCE_CYCLES, then produces one press.
- Synchroniser: two flops per button. There is no other path from btn_* into logic.
- Debounce, per button:
  - timer counts while sync_level != stable_level and clears whenever they are equal.
  - When timer reaches DEBOUNCE_CYCLES-1 while still different: stable_level flips and timer clears.
  - Glitches shorter than DEBOUNCE_CYCLES never flip stable_level.
- Press detect: stable_level rising 0->1 registers a pulse high for exactly one cycle. Release (1->0) produces no pulse.
- Latency: btn_up rises before edge E.
  - Sync output high after E+1.
  - stable flips after edge E+DEBOUNCE_CYCLES+1.
  - up_pulse high for the cycle after edge E+DEBOUNCE_CYCLES+2.
  - Q updated at edge E+DEBOUNCE_CYCLES+3.
- Count update, registered on the edge after the pulse:
  - up only: Q <= Q+1, modulo 16.
  - down only: Q <= Q-1, modulo 16.
  - up and down pulses in the same cycle: Q unchanged, wrap=0. Both pulses still assert.
  - neither: hold.
- wrap: asserted in the same cycle Q takes its new value, only on transitions 15->0 (up) or 0->15 (down).
- No state machine beyond per-button states IDLE (stable=0) and PRESSED (stable=1). With the optional feature, PRESSED is split into HOLD_WAIT and REPEAT.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined:
  - A button continuously stable-high for HOLD_CYCLES after its initial pulse enters REPEAT.
  - In REPEAT it emits an additional one-cycle pulse every REPEAT_CYCLES until stable goes low. Stable low returns it to IDLE and clears its timer.
  - Repeat pulses step Q and obey the simultaneous-pulse rule.
  - Reset returns both buttons to IDLE.
- Not defined: exactly one pulse per press regardless of hold time. Repeat timers and parameters are unused and are not synthesised.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=8, HOLD_CYCLES=40, REPEAT_CYCLES=10.
- Reset: hold reset=0 with buttons toggling, then release -> Q=0, all strobes 0, no pulse until a full debounce.
- Clean press: btn_up high 30 cycles from Q=0 -> one up_pulse at E+10, Q=1 at E+11, no pulse on release. Repeat 15 more presses -> Q=0 with wrap=1 on the final step.
- Bounce: btn_down toggles every 3 cycles for 40 cycles, then stays high -> exactly one down_pulse. From Q=0: Q=15, wrap=1.
- Short glitch: btn_up high 7 cycles, then low -> no pulse, Q unchanged.
- Simultaneous: both buttons rise on the same edge from Q=5 -> up_pulse and down_pulse in the same cycle, Q stays 5, wrap=0.
- Mid-press reset and auto-repeat:
  - Assert reset while btn_up is held, release reset with btn_up still held -> one pulse 8+ cycles later.
  - With BUTTON_AUTO_REPEAT_EN: hold btn_up 100 cycles -> Q advances 1 + floor((100-10-40)/10) = 6 (±1 on the boundary).
  - Without the macro: Q advances 1.
